blink_driver: RTL and testbench

//   Output-side counterpart of the input conditioning: turns a one-cycle

---
 rtl/blink_driver.sv | 140 ++++++++++++++
 tb/tb_blink_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/blink_driver.sv
// blink_driver
//   Turns a one-cycle request into a timed pattern of N blinks on one
//   indicator line. Each blink is ON_CYCLES high and then OFF_CYCLES low. The
//   last blink also gets its trailing off gap. All outputs are registered, so
//   downstream loads never see glitches or runt pulses.
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous reset, active high
//   i_start     one-cycle request, sampled only while idle
//   i_n_blinks  number of blinks to emit, latched together with i_start
//   i_cancel    abort the running pattern (no done pulse)
//   o_out       indicator drive
//   o_busy      high while a pattern runs, including the trailing off gap
//   o_done      one-cycle pulse on normal completion
module blink_driver #(
  parameter int unsigned ON_CYCLES  = 6000000,
  parameter int unsigned OFF_CYCLES = 6000000,
  parameter int unsigned CNT_W      = 23,
  parameter int unsigned N_W        = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N_W-1:0] i_n_blinks,
  input  logic           i_cancel,
  output logic           o_out,
  output logic           o_busy,
  output logic           o_done
);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_t;

  localparam logic [CNT_W-1:0] OnLast  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OffLast = CNT_W'(OFF_CYCLES - 1);

  state_t           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [N_W-1:0]   r_rem, w_rem_d;
  logic             r_out, w_out_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_rem   <= w_rem_d;
      r_out   <= w_out_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rem_d   = r_rem;
    w_out_d   = r_out;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Cancel in idle wins over a simultaneous start: the start is dropped.
        if (i_start && !i_cancel) begin
          if (i_n_blinks != '0) begin
            w_state_d = StOn;
            w_cnt_d   = '0;
            w_rem_d   = i_n_blinks;
            w_out_d   = 1'b1;
            w_busy_d  = 1'b1;
          end else begin
            w_done_d = 1'b1;
          end
        end
      end

      StOn: begin
        if (i_cancel) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_rem_d   = '0;
          w_out_d   = 1'b0;
          w_busy_d  = 1'b0;
        end else if (r_cnt == OnLast) begin
          w_state_d = StOff;
          w_cnt_d   = '0;
          w_rem_d   = r_rem - 1'b1;
          w_out_d   = 1'b0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      StOff: begin
        if (i_cancel) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_rem_d   = '0;
          w_out_d   = 1'b0;
          w_busy_d  = 1'b0;
        end else if (r_cnt == OffLast) begin
          w_cnt_d = '0;
          if (r_rem != '0) begin
            w_state_d = StOn;
            w_out_d   = 1'b1;
          end else begin
            // busy falls and done rises on the same edge.
            w_state_d = StIdle;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_rem_d   = '0;
        w_out_d   = 1'b0;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_blink_driver.sv
// tb_blink_driver
//   Directed scenarios followed by a random phase. Expected out/busy/done come
//   from a pattern-level model: an accepted request of n blinks defines a busy
//   window of n*(ON+OFF) cycles, with out high in the first ON cycles of every
//   period, and done on the cycle right after the window.
module tb_blink_driver;

  localparam int unsigned OnC  = 3;
  localparam int unsigned OffC = 2;
  localparam int unsigned Per  = OnC + OffC;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n_blinks;
  logic       cancel;
  logic       out;
  logic       busy;
  logic       done;

  blink_driver #(
    .ON_CYCLES (OnC),
    .OFF_CYCLES(OffC),
    .CNT_W     (3),
    .N_W       (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_n_blinks(n_blinks),
    .i_cancel  (cancel),
    .o_out     (out),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Pattern-level reference state.
  bit m_active  = 0;
  int m_elapsed = 0;
  int m_n       = 0;
  bit e_out, e_busy, e_done;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      $error("%s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, compare outputs.
  task automatic step(input logic s, input logic [3:0] n, input logic c, input logic r);
    start    = s;
    n_blinks = n;
    cancel   = c;
    rst      = r;
    @(posedge clk);
    cyc++;
    e_done = 0;
    if (r) begin
      m_active = 0;
    end else if (m_active) begin
      if (c) begin
        m_active = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_n * Per) begin
          m_active = 0;
          e_done   = 1;
        end
      end
    end else if (s && !c) begin
      if (n != 0) begin
        m_active  = 1;
        m_elapsed = 0;
        m_n       = int'(n);
      end else begin
        e_done = 1;
      end
    end
    e_busy = m_active;
    e_out  = m_active && ((m_elapsed % Per) < OnC);
    #1;
    chk("out", out, e_out);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    start    = 0;
    n_blinks = 0;
    cancel   = 0;
    rst      = 1;

    // Reset state.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // 1: reset mid-pattern, then a normal start.
    step(1, 3, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // 2: two blinks, 10 busy cycles, one done on the falling busy edge.
    busy_cnt = 0;
    done_cnt = 0;
    step(1, 2, 0, 0);
    busy_cnt += int'(busy);
    for (int k = 1; k < 11; k++) begin
      step(0, 4'(k), 0, 0);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    chk("t2_busy10", busy_cnt == 10, 1'b1);
    chk("t2_done1", done_cnt == 1, 1'b1);

    // 3: zero blinks -> done only.
    step(1, 0, 0, 0);
    chk("t3_out", out, 1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // 4: start during a pattern is ignored.
    busy_cnt = 0;
    step(1, 3, 0, 0);
    busy_cnt += int'(busy);
    for (int k = 1; k < 15; k++) begin
      step(k == 4, 4'd7, 0, 0);
      busy_cnt += int'(busy);
    end
    step(0, 0, 0, 0);
    busy_cnt += int'(busy);
    chk("t4_busy15", busy_cnt == 15, 1'b1);
    step(0, 0, 0, 0);

    // 5: cancel mid-pattern, done never asserts.
    done_cnt = 0;
    step(1, 5, 0, 0);
    for (int k = 1; k < 12; k++) begin
      step(0, 0, k == 6, 0);
      done_cnt += int'(done);
    end
    chk("t5_nodone", done_cnt == 0, 1'b1);

    // 6: restart on the done cycle.
    step(1, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    chk("t6_donecyc", done, 1'b1);
    step(1, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // Cancel in idle drops a simultaneous start.
    step(1, 2, 1, 0);
    step(0, 0, 0, 0);

    // Random phase.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 5)),
           $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
